// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the ADC phase-scan sequencer.
package adc_scan_pkg;

  localparam int unsigned METRIC_W = 12;
  localparam int unsigned DELAY_W  = 6;
  localparam logic [METRIC_W-1:0] METRIC_MAX = 12'hFFF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TRIG,
    S_SETTLE,
    S_COLLECT,
    S_EVAL,
    S_APPLY,
    S_FTRIG,
    S_FSETTLE,
    S_DONE
  } state_e;

endpackage

// File: rtl/adc_phase_scan_if.sv
// Link between the phase-scan sequencer (master) and adc_block (slave).
interface adc_phase_scan_if;

  logic [5:0] scan_delay;
  logic       delay_trig;
  logic       align_en;
  logic       monitor_strb;
  logic [6:0] count1;
  logic [6:0] count2;
  logic [6:0] count3;
  logic       saturated;

  modport master (
    output scan_delay, delay_trig, align_en,
    input  monitor_strb, count1, count2, count3, saturated
  );

  modport slave (
    input  scan_delay, delay_trig, align_en,
    output monitor_strb, count1, count2, count3, saturated
  );

endinterface

// File: rtl/scan_metric_accum.sv
// Per-step metric accumulator: sums count1+count3 over N monitor strobes and
// flags a timeout when strobes stop arriving.
module scan_metric_accum
  import adc_scan_pkg::*;
#(
  parameter logic [15:0] STRB_TIMEOUT = 16'hFFFF
) (
  input  logic                clk40,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic                strb,
  input  logic [6:0]          count1,
  input  logic [6:0]          count3,
  input  logic [3:0]          nstrb,
  output logic [METRIC_W-1:0] acc,
  output logic                step_valid,
  output logic                timeout
);

  logic [METRIC_W-1:0] acc_q, acc_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [15:0]         timer_q, timer_d;

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    step_valid = 1'b0;
    timeout    = 1'b0;
    if (clr) begin
      acc_d   = '0;
      cnt_d   = '0;
      timer_d = '0;
    end else if (en) begin
      if (strb) begin
        acc_d      = acc_q + METRIC_W'(count1) + METRIC_W'(count3);
        cnt_d      = cnt_q + 4'd1;
        timer_d    = '0;
        step_valid = (cnt_q == nstrb - 4'd1);
      end else begin
        timer_d = timer_q + 16'd1;
        timeout = (timer_q == STRB_TIMEOUT - 16'd1);
      end
    end
  end

  always_ff @(posedge clk40 or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/adc_phase_scan.sv
// ADC clock-phase sweep sequencer: scores each phase step and applies the best.
// Optional histogram of per-phase metrics when ADC_SCAN_HIST_EN is defined.
module adc_phase_scan
  import adc_scan_pkg::*;
#(
  parameter logic [15:0] STRB_TIMEOUT = 16'hFFFF
) (
  input  logic                clk40,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                align_en_req,
  input  logic [DELAY_W-1:0]  scan_first,
  input  logic [DELAY_W-1:0]  scan_last,
  input  logic [2:0]          scan_stride,
  input  logic [7:0]          settle_cycles,
  input  logic [3:0]          strobes_per_step,
  adc_phase_scan_if.master    adc,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                best_valid,
  output logic [DELAY_W-1:0]  best_delay,
  output logic [METRIC_W-1:0] best_metric
`ifdef ADC_SCAN_HIST_EN
  ,
  input  logic [DELAY_W-1:0]  hist_rd_addr,
  output logic [METRIC_W-1:0] hist_rd_data
`endif
);

  state_e              state_q, state_d;
  logic [DELAY_W-1:0]  delay_q, delay_d;
  logic                trig_q, trig_d;
  logic                align_q, align_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                bvalid_q, bvalid_d;
  logic [DELAY_W-1:0]  bdelay_q, bdelay_d;
  logic [METRIC_W-1:0] bmetric_q, bmetric_d;
  logic [DELAY_W-1:0]  orig_q, orig_d;
  logic [DELAY_W-1:0]  restore_q, restore_d;
  logic [DELAY_W-1:0]  first_q, first_d;
  logic [DELAY_W-1:0]  last_q, last_d;
  logic [2:0]          stride_q, stride_d;
  logic [7:0]          settle_q, settle_d;
  logic [3:0]          nstrb_q, nstrb_d;
  logic [7:0]          scnt_q, scnt_d;

  logic                acc_clr;
  logic [METRIC_W-1:0] acc;
  logic                step_valid;
  logic                timeout;
  logic [DELAY_W:0]    next_phase;
  logic                better;
  logic                sat_hit;
  logic                abort_hit;
  logic                unused_count2;

  assign unused_count2 = ^adc.count2;

  scan_metric_accum #(
    .STRB_TIMEOUT (STRB_TIMEOUT)
  ) u_accum (
    .clk40      (clk40),
    .rst_n      (rst_n),
    .clr        (acc_clr),
    .en         (state_q == S_COLLECT),
    .strb       (adc.monitor_strb),
    .count1     (adc.count1),
    .count3     (adc.count3),
    .nstrb      (nstrb_q),
    .acc        (acc),
    .step_valid (step_valid),
    .timeout    (timeout)
  );

  assign busy       = (state_q != S_IDLE);
  assign next_phase = {1'b0, delay_q} + {4'b0, stride_q};
  assign better     = (acc < bmetric_q);
  assign sat_hit    = adc.saturated & (state_q inside {S_SETTLE, S_COLLECT});
  assign abort_hit  = abort & (state_q inside {S_TRIG, S_SETTLE, S_COLLECT, S_EVAL});

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    trig_d    = 1'b0;
    error_d   = error_q;
    bvalid_d  = bvalid_q;
    bdelay_d  = bdelay_q;
    bmetric_d = bmetric_q;
    orig_d    = orig_q;
    restore_d = restore_q;
    first_d   = first_q;
    last_d    = last_q;
    stride_d  = stride_q;
    settle_d  = settle_q;
    nstrb_d   = nstrb_q;
    scnt_d    = scnt_q;
    acc_clr   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          first_d   = scan_first;
          last_d    = scan_last;
          stride_d  = (scan_stride == 3'd0) ? 3'd1 : scan_stride;
          settle_d  = (settle_cycles == 8'd0) ? 8'd1 : settle_cycles;
          nstrb_d   = (strobes_per_step == 4'd0) ? 4'd1 : strobes_per_step;
          orig_d    = delay_q;
          error_d   = 1'b0;
          bvalid_d  = 1'b0;
          bmetric_d = METRIC_MAX;
          if (scan_first > scan_last) begin
            error_d   = 1'b1;
            restore_d = delay_q;
            state_d   = S_APPLY;
          end else begin
            delay_d = scan_first;
            state_d = S_TRIG;
          end
        end
      end
      S_TRIG: begin
        trig_d  = 1'b1;
        scnt_d  = settle_q;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (scnt_q <= 8'd1) begin
          acc_clr = 1'b1;
          state_d = S_COLLECT;
        end else begin
          scnt_d = scnt_q - 8'd1;
        end
      end
      S_COLLECT: begin
        if (step_valid) begin
          state_d = S_EVAL;
        end else if (timeout) begin
          error_d   = 1'b1;
          restore_d = orig_q;
          state_d   = S_APPLY;
        end
      end
      S_EVAL: begin
        if (better) begin
          bmetric_d = acc;
          bdelay_d  = delay_q;
          bvalid_d  = 1'b1;
        end
        // Restore target must see a best updated in this same cycle.
        if (next_phase > {1'b0, last_q}) begin
          restore_d = better ? delay_q : bdelay_q;
          state_d   = S_APPLY;
        end else begin
          delay_d = next_phase[DELAY_W-1:0];
          state_d = S_TRIG;
        end
      end
      S_APPLY: begin
        delay_d = restore_q;
        state_d = S_FTRIG;
      end
      S_FTRIG: begin
        trig_d  = 1'b1;
        scnt_d  = settle_q;
        state_d = S_FSETTLE;
      end
      S_FSETTLE: begin
        if (scnt_q <= 8'd1) begin
          state_d = S_DONE;
        end else begin
          scnt_d = scnt_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Saturation outranks abort; both discard this cycle's step/trigger work.
    if (sat_hit) begin
      state_d   = S_APPLY;
      restore_d = orig_q;
      error_d   = 1'b1;
      delay_d   = delay_q;
      trig_d    = 1'b0;
    end else if (abort_hit) begin
      state_d   = S_APPLY;
      restore_d = orig_q;
      error_d   = error_q;
      bvalid_d  = 1'b0;
      bdelay_d  = bdelay_q;
      bmetric_d = bmetric_q;
      delay_d   = delay_q;
      trig_d    = 1'b0;
    end

    done_d  = (state_d == S_DONE);
    align_d = align_en_req & ~busy;
  end

  always_ff @(posedge clk40 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      delay_q   <= '0;
      trig_q    <= 1'b0;
      align_q   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      bdelay_q  <= '0;
      bmetric_q <= METRIC_MAX;
      orig_q    <= '0;
      restore_q <= '0;
      first_q   <= '0;
      last_q    <= '0;
      stride_q  <= 3'd1;
      settle_q  <= 8'd1;
      nstrb_q   <= 4'd1;
      scnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      trig_q    <= trig_d;
      align_q   <= align_d;
      done_q    <= done_d;
      error_q   <= error_d;
      bvalid_q  <= bvalid_d;
      bdelay_q  <= bdelay_d;
      bmetric_q <= bmetric_d;
      orig_q    <= orig_d;
      restore_q <= restore_d;
      first_q   <= first_d;
      last_q    <= last_d;
      stride_q  <= stride_d;
      settle_q  <= settle_d;
      nstrb_q   <= nstrb_d;
      scnt_q    <= scnt_d;
    end
  end

  assign adc.scan_delay = delay_q;
  assign adc.delay_trig = trig_q;
  assign adc.align_en   = align_q;
  assign done           = done_q;
  assign error          = error_q;
  assign best_valid     = bvalid_q;
  assign best_delay     = bdelay_q;
  assign best_metric    = bmetric_q;

`ifdef ADC_SCAN_HIST_EN
  logic [METRIC_W-1:0] hist_q [64];
  logic [METRIC_W-1:0] hist_d [64];
  logic [METRIC_W-1:0] hist_rd_q;

  always_comb begin
    hist_d = hist_q;
    if (state_q == S_IDLE && start) begin
      for (int unsigned i = 0; i < 64; i++) hist_d[i] = '0;
    end else if (state_q == S_EVAL) begin
      hist_d[delay_q] = acc;
    end
  end

  always_ff @(posedge clk40 or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 64; i++) hist_q[i] <= '0;
      hist_rd_q <= '0;
    end else begin
      hist_q    <= hist_d;
      hist_rd_q <= hist_q[hist_rd_addr];
    end
  end

  assign hist_rd_data = hist_rd_q;
`endif

endmodule

// File: tb/tb_adc_phase_scan.sv
// Directed self-checking bench for adc_phase_scan with a simple adc_block stand-in.
module tb_adc_phase_scan;

  logic        clk40;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        align_en_req;
  logic [5:0]  scan_first;
  logic [5:0]  scan_last;
  logic [2:0]  scan_stride;
  logic [7:0]  settle_cycles;
  logic [3:0]  strobes_per_step;
  logic        busy;
  logic        done;
  logic        error;
  logic        best_valid;
  logic [5:0]  best_delay;
  logic [11:0] best_metric;
`ifdef ADC_SCAN_HIST_EN
  logic [5:0]  hist_rd_addr;
  logic [11:0] hist_rd_data;
`endif

  adc_phase_scan_if adc_if ();

  adc_phase_scan #(
    .STRB_TIMEOUT (16'd100)
  ) dut (
    .clk40            (clk40),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .align_en_req     (align_en_req),
    .scan_first       (scan_first),
    .scan_last        (scan_last),
    .scan_stride      (scan_stride),
    .settle_cycles    (settle_cycles),
    .strobes_per_step (strobes_per_step),
    .adc              (adc_if.master),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .best_valid       (best_valid),
    .best_delay       (best_delay),
    .best_metric      (best_metric)
`ifdef ADC_SCAN_HIST_EN
    ,
    .hist_rd_addr     (hist_rd_addr),
    .hist_rd_data     (hist_rd_data)
`endif
  );

  typedef struct {
    logic [5:0]  first;
    logic [5:0]  last;
    logic [2:0]  stride;
    logic [7:0]  settle;
    logic [3:0]  nstrb;
    int          pat;
    bit          strb_on;
    int          sat_at;
    int          abort_at;
    int          err_at;
    int          cycles;
    int          trigs;
    logic [5:0]  bd;
    logic [11:0] bm;
    bit          bv;
    bit          err;
    logic [5:0]  fin;
  } vec_t;

  vec_t       vecs [11];
  int         errors = 0;
  int         checks = 0;
  int         pat    = 0;
  bit         strb_on = 1'b0;
  logic [5:0] trig_log [$];

  initial begin
    clk40 = 1'b0;
    forever #5 clk40 = ~clk40;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  function automatic int metric(input int p);
    int d;
    case (pat)
      0: metric = (p == 10) ? 40 : (p == 15) ? 8 : (p == 20) ? 30 : 100;
      1: metric = 5;
      default: begin
        d = (p > 25) ? p - 25 : 25 - p;
        metric = 2 * d;
      end
    endcase
  endfunction

  // adc_block stand-in: strobes every cycle with counts derived from the phase.
  always @(negedge clk40) begin : adc_model
    int m;
    if (strb_on) begin
      m = metric(int'(adc_if.scan_delay));
      adc_if.monitor_strb = 1'b1;
      adc_if.count1 = 7'(m / 2);
      adc_if.count3 = 7'(m - m / 2);
    end else begin
      adc_if.monitor_strb = 1'b0;
      adc_if.count1 = '0;
      adc_if.count3 = '0;
    end
    if (adc_if.delay_trig === 1'b1) trig_log.push_back(adc_if.scan_delay);
  end

  task automatic tick;
    @(posedge clk40);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    bit   valid_win;
    bit   got;
    int   n;
    v = vecs[i];
    valid_win = (v.first <= v.last);
    scan_first = v.first;
    scan_last = v.last;
    scan_stride = v.stride;
    settle_cycles = v.settle;
    strobes_per_step = v.nstrb;
    pat = v.pat;
    strb_on = v.strb_on;
    trig_log.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    got = 1'b0;
    while (n <= 400 && !got) begin
      if (n == 1) begin
        chk($sformatf("v%0d busy_n1", i), 32'(busy), 32'(1));
        if (valid_win) chk($sformatf("v%0d delay_n1", i), 32'(adc_if.scan_delay), 32'(v.first));
        chk($sformatf("v%0d trig_n1", i), 32'(adc_if.delay_trig), 32'(0));
        chk($sformatf("v%0d align_n1", i), 32'(adc_if.align_en), 32'(1));
      end
      if (n == 2) begin
        chk($sformatf("v%0d trig_n2", i), 32'(adc_if.delay_trig), 32'(valid_win));
        chk($sformatf("v%0d align_n2", i), 32'(adc_if.align_en), 32'(0));
      end
      if (v.err_at != 0 && n == v.err_at - 1) chk($sformatf("v%0d err_pre", i), 32'(error), 32'(0));
      if (v.err_at != 0 && n == v.err_at) chk($sformatf("v%0d err_at", i), 32'(error), 32'(1));
      adc_if.saturated = (n == v.sat_at);
      abort = (n == v.abort_at);
      if (done === 1'b1) got = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    adc_if.saturated = 1'b0;
    abort = 1'b0;
    chk($sformatf("v%0d done_cycle", i), 32'(n), 32'(v.cycles));
    chk($sformatf("v%0d error", i), 32'(error), 32'(v.err));
    chk($sformatf("v%0d best_valid", i), 32'(best_valid), 32'(v.bv));
    chk($sformatf("v%0d best_delay", i), 32'(best_delay), 32'(v.bd));
    chk($sformatf("v%0d best_metric", i), 32'(best_metric), 32'(v.bm));
    chk($sformatf("v%0d final_delay", i), 32'(adc_if.scan_delay), 32'(v.fin));
    chk($sformatf("v%0d trig_count", i), 32'(trig_log.size()), 32'(v.trigs));
    chk($sformatf("v%0d last_trig", i),
        (trig_log.size() > 0) ? 32'(trig_log[trig_log.size() - 1]) : 32'hFFFF_FFFF, 32'(v.fin));
    tick();
    chk($sformatf("v%0d done_pulse", i), 32'(done), 32'(0));
    chk($sformatf("v%0d idle", i), 32'(busy), 32'(0));
    repeat (3) tick();
  endtask

  initial begin
    int exp_ph [4];
    vecs[0]  = '{6'd10, 6'd20, 3'd5, 8'd3, 4'd1,  0, 1'b1, 0,  0, 0,   24,  4, 6'd15, 12'd8,    1'b1, 1'b0, 6'd15};
    vecs[1]  = '{6'd0,  6'd3,  3'd1, 8'd1, 4'd1,  1, 1'b1, 0,  0, 0,   20,  5, 6'd0,  12'd5,    1'b1, 1'b0, 6'd0};
    vecs[2]  = '{6'd20, 6'd30, 3'd0, 8'd0, 4'd2,  2, 1'b1, 0,  0, 0,   59, 12, 6'd25, 12'd0,    1'b1, 1'b0, 6'd25};
    vecs[3]  = '{6'd0,  6'd63, 3'd7, 8'd2, 4'd3,  2, 1'b1, 0,  0, 0,   75, 11, 6'd28, 12'd18,   1'b1, 1'b0, 6'd28};
    vecs[4]  = '{6'd5,  6'd5,  3'd3, 8'd4, 4'd0,  2, 1'b1, 0,  0, 0,   14,  2, 6'd5,  12'd40,   1'b1, 1'b0, 6'd5};
    vecs[5]  = '{6'd62, 6'd63, 3'd7, 8'd1, 4'd15, 2, 1'b1, 0,  0, 0,   22,  2, 6'd62, 12'd1110, 1'b1, 1'b0, 6'd62};
    vecs[6]  = '{6'd10, 6'd20, 3'd5, 8'd3, 4'd1,  2, 1'b1, 0,  8, 0,   14,  3, 6'd10, 12'd30,   1'b0, 1'b0, 6'd62};
    vecs[7]  = '{6'd33, 6'd33, 3'd1, 8'd1, 4'd1,  2, 1'b1, 0,  0, 0,    8,  2, 6'd33, 12'd16,   1'b1, 1'b0, 6'd33};
    vecs[8]  = '{6'd10, 6'd20, 3'd5, 8'd3, 4'd1,  2, 1'b1, 11, 0, 0,   17,  3, 6'd10, 12'd30,   1'b1, 1'b1, 6'd33};
    vecs[9]  = '{6'd30, 6'd20, 3'd1, 8'd2, 4'd1,  2, 1'b1, 0,  0, 0,    5,  1, 6'd10, 12'hFFF,  1'b0, 1'b1, 6'd33};
    vecs[10] = '{6'd5,  6'd9,  3'd1, 8'd2, 4'd1,  2, 1'b0, 0,  0, 104, 108, 2, 6'd10, 12'hFFF,  1'b0, 1'b1, 6'd33};
    exp_ph = '{10, 15, 20, 15};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    align_en_req = 1'b1;
    scan_first = '0;
    scan_last = '0;
    scan_stride = '0;
    settle_cycles = '0;
    strobes_per_step = '0;
    adc_if.monitor_strb = 1'b0;
    adc_if.count1 = '0;
    adc_if.count2 = '0;
    adc_if.count3 = '0;
    adc_if.saturated = 1'b0;
`ifdef ADC_SCAN_HIST_EN
    hist_rd_addr = '0;
`endif
    tick();
    chk("rst scan_delay", 32'(adc_if.scan_delay), 32'(0));
    chk("rst delay_trig", 32'(adc_if.delay_trig), 32'(0));
    chk("rst align_en", 32'(adc_if.align_en), 32'(0));
    chk("rst busy", 32'(busy), 32'(0));
    chk("rst done", 32'(done), 32'(0));
    chk("rst error", 32'(error), 32'(0));
    chk("rst best_valid", 32'(best_valid), 32'(0));
    chk("rst best_delay", 32'(best_delay), 32'(0));
    chk("rst best_metric", 32'(best_metric), 32'(12'hFFF));
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst align_en", 32'(adc_if.align_en), 32'(1));

    for (int i = 0; i < 11; i++) begin
      run_vec(i);
      if (i == 0) begin
        for (int k = 0; k < 4; k++)
          chk($sformatf("v0 trig_phase%0d", k),
              (k < trig_log.size()) ? 32'(trig_log[k]) : 32'hFFFF_FFFF, 32'(exp_ph[k]));
      end
    end

    // Reset asserted while the first step is settling.
    scan_first = 6'd10;
    scan_last = 6'd20;
    scan_stride = 3'd5;
    settle_cycles = 8'd10;
    strobes_per_step = 4'd1;
    strb_on = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst scan_delay", 32'(adc_if.scan_delay), 32'(0));
    chk("midrst delay_trig", 32'(adc_if.delay_trig), 32'(0));
    chk("midrst busy", 32'(busy), 32'(0));
    chk("midrst error", 32'(error), 32'(0));
    chk("midrst best_delay", 32'(best_delay), 32'(0));
    chk("midrst best_metric", 32'(best_metric), 32'(12'hFFF));
    chk("midrst align_en", 32'(adc_if.align_en), 32'(0));
    tick();
    tick();
    rst_n = 1'b1;
    trig_log.delete();
    repeat (30) tick();
    chk("postrst trig_count", 32'(trig_log.size()), 32'(0));
    chk("postrst busy", 32'(busy), 32'(0));
    chk("postrst scan_delay", 32'(adc_if.scan_delay), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
